// File: rtl/btisa_seq_if.sv
// Handshake and control bundle between the BTISA sequencer and the surrounding datapath/memories.
interface btisa_seq_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             imem_req;
    logic             imem_ready;
    logic             ir_load;
    logic             dec_reg_write;
    logic             dec_mem_read;
    logic             dec_mem_write;
    logic             dec_branch;
    logic             dec_jump;
    logic             dec_halt;
    logic             branch_taken;
    logic             alu_en;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ready;
    logic             rf_we;
    logic             pc_inc;
    logic             pc_load;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        input  run, imem_ready, dec_reg_write, dec_mem_read, dec_mem_write,
               dec_branch, dec_jump, dec_halt, branch_taken, dmem_ready,
        output imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we,
               pc_inc, pc_load, halted, fault, retired_cnt
    );

    modport slave (
        output run, imem_ready, dec_reg_write, dec_mem_read, dec_mem_write,
               dec_branch, dec_jump, dec_halt, branch_taken, dmem_ready,
        input  imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we,
               pc_inc, pc_load, halted, fault, retired_cnt
    );
endinterface

// File: rtl/btisa_seq_ctrl.sv
// Multi-cycle BTISA sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB, with sticky halt/fault
// states, a bounded wait on memory handshakes and a retired-instruction counter.
module btisa_seq_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    btisa_seq_if.master bus
);
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t             state_reg, state_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]   retired_reg, retired_next;
    logic               pending_reg, pending_next;

    logic imem_req_c, ir_load_c, alu_en_c, dmem_req_c, dmem_we_c;
    logic rf_we_c, pc_inc_c, pc_load_c, halted_c, fault_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            retired_reg  <= '0;
            pending_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            retired_reg  <= retired_next;
            pending_reg  <= pending_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        retired_next  = retired_reg;
        pending_next  = pending_reg;
        imem_req_c    = 1'b0;
        ir_load_c     = 1'b0;
        alu_en_c      = 1'b0;
        dmem_req_c    = 1'b0;
        dmem_we_c     = 1'b0;
        rf_we_c       = 1'b0;
        pc_inc_c      = 1'b0;
        pc_load_c     = 1'b0;
        halted_c      = 1'b0;
        fault_c       = 1'b0;

        case (state_reg)
            S_FETCH: begin
                // Once raised the request must hold until accepted, even if run drops.
                imem_req_c = bus.run | pending_reg;
                if (imem_req_c) begin
                    if (bus.imem_ready) begin
                        ir_load_c    = 1'b1;
                        pending_next = 1'b0;
                        state_next   = S_DECODE;
                    end else if (wait_cnt_reg == WAIT_LIMIT) begin
                        pending_next = 1'b0;
                        state_next   = S_FAULT;
                    end else begin
                        pending_next  = 1'b1;
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                    end
                end
            end
            S_DECODE: begin
                if (bus.dec_halt) begin
                    retired_next = retired_reg + 1'b1;
                    state_next   = S_HALTED;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_en_c = 1'b1;
                if (bus.dec_mem_read | bus.dec_mem_write) begin
                    wait_cnt_next = '0;
                    state_next    = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = bus.dec_mem_write;
                if (bus.dmem_ready) begin
                    state_next = S_WB;
                end else if (wait_cnt_reg == WAIT_LIMIT) begin
                    state_next = S_FAULT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_WB: begin
                rf_we_c       = bus.dec_reg_write & ~bus.dec_mem_write;
                pc_load_c     = bus.dec_jump | (bus.dec_branch & bus.branch_taken);
                pc_inc_c      = ~pc_load_c;
                retired_next  = retired_reg + 1'b1;
                wait_cnt_next = '0;
                state_next    = S_FETCH;
            end
            S_HALTED: halted_c = 1'b1;
            S_FAULT:  fault_c  = 1'b1;
            default:  state_next = S_FETCH;
        endcase

        // Keep every output quiet while reset is held, whatever state we are leaving.
        if (rst) begin
            imem_req_c = 1'b0;
            ir_load_c  = 1'b0;
            alu_en_c   = 1'b0;
            dmem_req_c = 1'b0;
            dmem_we_c  = 1'b0;
            rf_we_c    = 1'b0;
            pc_inc_c   = 1'b0;
            pc_load_c  = 1'b0;
            halted_c   = 1'b0;
            fault_c    = 1'b0;
        end
    end

    assign bus.imem_req    = imem_req_c;
    assign bus.ir_load     = ir_load_c;
    assign bus.alu_en      = alu_en_c;
    assign bus.dmem_req    = dmem_req_c;
    assign bus.dmem_we     = dmem_we_c;
    assign bus.rf_we       = rf_we_c;
    assign bus.pc_inc      = pc_inc_c;
    assign bus.pc_load     = pc_load_c;
    assign bus.halted      = halted_c;
    assign bus.fault       = fault_c;
    assign bus.retired_cnt = retired_reg;
endmodule
